// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// Pipeline stage register with a valid/ready handshake backed by a
// two-entry skid buffer (main = head, skid = overflow), synchronous flush
// and a saturating bubble counter for stall profiling.
//
// Ports:
//   clk, rst         rising-edge clock, async active-low reset
//   in_valid/ready   upstream handshake (in_ready is a flop output)
//   in_data/in_ctrl  upstream payload and control bits
//   flush            synchronous squash of all held beats
//   out_valid/ready  downstream handshake
//   out_data         head payload (holds last value while invalid)
//   out_ctrl         head control, forced to 0 when out_valid=0
//   cnt_clr          synchronous clear of bubble_cnt
//   bubble_cnt       saturating count of starved cycles
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Encoding is {skid_valid, main_valid}.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_TWO   = 2'b11
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_main_data, w_main_data_nxt;
  logic [CTRL_W-1:0]   r_main_ctrl, w_main_ctrl_nxt;
  logic [DATA_W-1:0]   r_skid_data, w_skid_data_nxt;
  logic [CTRL_W-1:0]   r_skid_ctrl, w_skid_ctrl_nxt;
  logic [CNT_W-1:0]    r_cnt;

  logic w_main_vld, w_skid_vld, w_push, w_pop;

  assign w_main_vld = r_state[0];
  assign w_skid_vld = r_state[1];

  // Ready depends only on state flops, so no combinational path from
  // out_ready back to in_ready.
  assign in_ready   = ~w_skid_vld;
  assign out_valid  = w_main_vld;
  assign out_data   = r_main_data;
  assign out_ctrl   = w_main_vld ? r_main_ctrl : '0;
  assign bubble_cnt = r_cnt;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_main_data_nxt = r_main_data;
    w_main_ctrl_nxt = r_main_ctrl;
    w_skid_data_nxt = r_skid_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    if (flush) begin
      // Squash drops held beats and any beat offered this cycle.
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            w_state_nxt     = S_ONE;
            w_main_data_nxt = in_data;
            w_main_ctrl_nxt = in_ctrl;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            w_main_data_nxt = in_data;
            w_main_ctrl_nxt = in_ctrl;
          end else if (w_push) begin
            w_state_nxt     = S_TWO;
            w_skid_data_nxt = in_data;
            w_skid_ctrl_nxt = in_ctrl;
          end else if (w_pop) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            w_state_nxt     = S_ONE;
            w_main_data_nxt = r_skid_data;
            w_main_ctrl_nxt = r_skid_ctrl;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_main_data <= w_main_data_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
    end
  end

  // Starved cycle: consumer ready but nothing to give it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (out_ready && !out_valid && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
  localparam int DW = 16;
  localparam int CW = 3;
  localparam int NW = 4;
  localparam int CMAX = (1 << NW) - 1;

  logic          clk = 0;
  logic          rst = 0;
  logic          in_valid = 0, in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          flush = 0;
  logic          out_valid, out_ready = 0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          cnt_clr = 0;
  logic [NW-1:0] bubble_cnt;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  beat_t q[$];     // expected beats, in arrival order
  int    mcnt = 0; // expected bubble count

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl),
    .cnt_clr(cnt_clr), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs only change just after posedge, so at negedge they are
  // the values the next edge will see. Check outputs, then advance model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_ctrl", out_ctrl, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_cnt", bubble_cnt, 0);
      q.delete();
      mcnt = 0;
    end else begin
      bit rdy, pop, push;
      rdy = (q.size() < 2);
      chk("in_ready", in_ready, rdy);
      chk("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_ctrl", out_ctrl, q[0].c);
      end else begin
        chk("bubble_ctrl", out_ctrl, 0);
      end
      chk("bubble_cnt", bubble_cnt, mcnt);
      pop  = (q.size() > 0) && out_ready;
      push = in_valid && rdy;
      if (cnt_clr) mcnt = 0;
      else if (out_ready && q.size() == 0 && mcnt < CMAX) mcnt++;
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back('{d: in_data, c: in_ctrl});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                     input bit ordy, input bit fl, input bit clr);
    in_valid = iv; in_data = d; in_ctrl = c;
    out_ready = ordy; flush = fl; cnt_clr = clr;
    step();
  endtask

  initial begin
    repeat (3) step();
    rst = 1;

    // Accumulate some bubbles, then fill both entries.
    repeat (3) drv(0, 0, 0, 1, 0, 0);
    drv(1, 16'hA, 3'b001, 0, 0, 0);
    drv(1, 16'hB, 3'b010, 0, 0, 0);
    in_valid = 0;
    chk("two_in_ready", in_ready, 0);
    chk("two_head", out_data, 16'hA);

    // Async reset mid-stream: visible before the next clock edge.
    #1 rst = 0;
    #2;
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 1);
    chk("async_cnt", bubble_cnt, 0);
    step();
    rst = 1;
    out_ready = 1;
    repeat (5) step();
    chk("cnt_after_5", bubble_cnt, 5);

    // Streaming 1..8, back-to-back.
    for (int i = 1; i <= 8; i++) drv(1, i[DW-1:0], 3'b011, 1, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 1, 0, 0);

    // Backpressure: A, B into skid; C waits until in_ready returns.
    drv(1, 16'h00A1, 3'b100, 0, 0, 0);
    drv(1, 16'h00B2, 3'b101, 0, 0, 0);
    drv(1, 16'h00C3, 3'b110, 0, 0, 0);
    drv(1, 16'h00C3, 3'b110, 0, 0, 0);
    begin
      bit took = 0;
      for (int k = 0; k < 10 && !took; k++) begin
        bit r = in_ready;
        drv(1, 16'h00C3, 3'b110, 1, 0, 0);
        took = r;
      end
      chk("c_accepted", took, 1);
    end
    repeat (4) drv(0, 0, 0, 1, 0, 0);

    // Flush in TWO with C offered: nothing survives.
    drv(1, 16'h0A0A, 3'b111, 0, 0, 0);
    drv(1, 16'h0B0B, 3'b111, 0, 0, 0);
    drv(1, 16'h0C0C, 3'b111, 0, 1, 0);
    in_valid = 0; flush = 0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_ctrl", out_ctrl, 0);
    chk("flush_in_ready", in_ready, 1);
    repeat (3) drv(0, 0, 0, 1, 0, 0);

    // Bubble after ctrl=111 beat drains.
    drv(1, 16'h0777, 3'b111, 1, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    chk("post_bubble_ctrl", out_ctrl, 0);

    // Saturation then clear with a starved cycle.
    repeat (20) drv(0, 0, 0, 1, 0, 0);
    chk("cnt_sat", bubble_cnt, CMAX);
    drv(0, 0, 0, 1, 0, 1);
    chk("cnt_clr", bubble_cnt, 0);

    // Flush together with cnt_clr.
    drv(1, 16'h1234, 3'b011, 0, 0, 0);
    drv(0, 0, 0, 1, 1, 1);
    chk("flush_clr_valid", out_valid, 0);
    chk("flush_clr_cnt", bubble_cnt, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      drv($urandom_range(0, 3) != 0, DW'($urandom), CW'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 31) == 0);

    // Drain and confirm nothing left behind.
    repeat (4) drv(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("drained", q.size(), 0);
    chk("final_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
